// File: rtl/raiden_bcd_pkg.sv
// raiden_bcd_pkg: shared BCD widths, FSM encoding and digit-range helper for the BCD/binary converters
package raiden_bcd_pkg;
  localparam int BCD_DIGIT_W = 4;
  localparam int DIGITS = 3;
  localparam int BIN_W = 10;
  localparam int BCD_MAX_DIGIT = 9;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  function automatic logic digit_bad(input logic [BCD_DIGIT_W-1:0] d);
    return d > BCD_DIGIT_W'(BCD_MAX_DIGIT);
  endfunction
endpackage

// File: rtl/bcd_digit_corr.sv
// bcd_digit_corr: reverse double-dabble digit fix-up, subtract 3 from any digit of 8 or more
module bcd_digit_corr
  import raiden_bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] i_digit,
  output logic [BCD_DIGIT_W-1:0] o_digit
);
  always_comb o_digit = i_digit[BCD_DIGIT_W-1] ? i_digit - BCD_DIGIT_W'(3) : i_digit;
endmodule

// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq: sequential BCD-to-binary converter, one shift per clock; BCD2BIN_RANGE_CHECK_EN enables digit range check
module bcd_to_bin_seq #(
  parameter int DIGITS = raiden_bcd_pkg::DIGITS,
  parameter int BIN_W = raiden_bcd_pkg::BIN_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       Hundreds,
  input  logic [3:0]       Tens,
  input  logic [3:0]       Ones,
  output logic [BIN_W-1:0] binary,
  output logic             busy,
  output logic             done,
  output logic             err
);
  import raiden_bcd_pkg::*;
  localparam int BW = BCD_DIGIT_W * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);
  logic [1:0]       r_state;
  logic [BW-1:0]    r_bcd, w_bcd_sh, w_bcd_nx;
  logic [BIN_W-1:0] r_bin, w_bin_nx, r_binary;
  logic [CW-1:0]    r_cnt;
  logic             r_err, w_bad;
  assign {w_bcd_sh, w_bin_nx} = {r_bcd, r_bin} >> 1;
  for (genvar d = 0; d < DIGITS; d++) begin : g_corr
    bcd_digit_corr u_corr (
      .i_digit(w_bcd_sh[d*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .o_digit(w_bcd_nx[d*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end
`ifdef BCD2BIN_RANGE_CHECK_EN
  assign w_bad = digit_bad(Hundreds) | digit_bad(Tens) | digit_bad(Ones);
`else
  assign w_bad = 1'b0;
`endif
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_bcd    <= '0;
      r_bin    <= '0;
      r_cnt    <= '0;
      r_binary <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_err   <= w_bad;
          r_bcd   <= {Hundreds, Tens, Ones};
          r_bin   <= '0;
          r_cnt   <= CW'(BIN_W);
          r_state <= w_bad ? S_DONE : S_SHIFT;
          if (w_bad) r_binary <= '1;
        end
        S_SHIFT: begin
          r_bcd <= w_bcd_nx;
          r_bin <= w_bin_nx;
          r_cnt <= r_cnt - CW'(1);
          // last shift lands directly in the output register
          if (r_cnt == CW'(1)) begin
            r_state  <= S_DONE;
            r_binary <= w_bin_nx;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign binary = r_binary;
  assign busy   = r_state == S_SHIFT;
  assign done   = r_state == S_DONE;
  assign err    = r_err;
endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// tb_bcd_to_bin_seq: directed table-driven checks of bcd_to_bin_seq plus handshake corner cases
module tb_bcd_to_bin_seq;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [3:0] h = 4'd0, t = 4'd0, o = 4'd0;
  logic [9:0] binary;
  logic busy, done, err;
  int n_cmp = 0, n_bad = 0;

  typedef struct {
    logic [3:0] h, t, o;
    logic [9:0] b;
  } vec_t;
  vec_t vec [12];

  bcd_to_bin_seq dut (
    .clock(clk), .reset(rst), .start(start), .Hundreds(h), .Tens(t), .Ones(o),
    .binary(binary), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  task automatic run(input logic [3:0] ih, it, io, input logic [9:0] eb, input logic eerr,
                     input int elat, input bit cb, input int repulse, input string nm);
    int n = 0, nb = 0;
    h = ih; t = it; o = io; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!done && n < 40) begin
      if (busy) nb++;
      if (n == repulse) begin start = 1'b1; h = 4'd1; t = 4'd1; o = 4'd1; end
      else start = 1'b0;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk({nm, " latency"}, n, elat);
    chk({nm, " busy_cycles"}, nb, elat);
    if (cb) chk({nm, " binary"}, binary, eb);
    chk({nm, " err"}, err, eerr);
    @(negedge clk);
    chk({nm, " done_pulse"}, done, 0);
    if (cb) chk({nm, " binary_hold"}, binary, eb);
  endtask

  initial begin
    vec[0]  = '{4'd9, 4'd9, 4'd9, 10'h3E7};
    vec[1]  = '{4'd0, 4'd0, 4'd0, 10'h000};
    vec[2]  = '{4'd2, 4'd5, 4'd5, 10'h0FF};
    vec[3]  = '{4'd1, 4'd2, 4'd8, 10'h080};
    vec[4]  = '{4'd5, 4'd1, 4'd2, 10'h200};
    vec[5]  = '{4'd0, 4'd0, 4'd1, 10'h001};
    vec[6]  = '{4'd0, 4'd0, 4'd9, 10'h009};
    vec[7]  = '{4'd0, 4'd1, 4'd0, 10'h00A};
    vec[8]  = '{4'd0, 4'd9, 4'd0, 10'h05A};
    vec[9]  = '{4'd1, 4'd0, 4'd0, 10'h064};
    vec[10] = '{4'd6, 4'd3, 4'd7, 10'h27D};
    vec[11] = '{4'd8, 4'd0, 4'd8, 10'h328};
    repeat (3) @(negedge clk);
    chk("reset binary", binary, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset err", err, 0);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 12; i++)
      run(vec[i].h, vec[i].t, vec[i].o, vec[i].b, 1'b0, 10, 1'b1, -1, $sformatf("vec%0d", i));

    run(4'd1, 4'd2, 4'd8, 10'h080, 1'b0, 10, 1'b1, 2, "restart_ignored");

    begin
      h = 4'd9; t = 4'd9; o = 4'd9; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort busy", busy, 0);
      chk("abort done", done, 0);
      chk("abort binary", binary, 0);
      begin
        int seen = 0;
        repeat (15) begin @(negedge clk); if (done || busy) seen++; end
        chk("abort no_done", seen, 0);
      end
    end

`ifdef BCD2BIN_RANGE_CHECK_EN
    run(4'd0, 4'hA, 4'd0, 10'h3FF, 1'b1, 0, 1'b1, -1, "range_err");
    run(4'd1, 4'd2, 4'd3, 10'h07B, 1'b0, 10, 1'b1, -1, "range_clear");
`else
    run(4'd0, 4'hA, 4'd0, 10'h000, 1'b0, 10, 1'b0, -1, "bad_digit_noerr");
`endif

    begin
      int k, last = 0, cyc = 0;
      h = vec[2].h; t = vec[2].t; o = vec[2].o; start = 1'b1;
      for (int i = 0; i < 4; i++) begin
        k = 0;
        do begin @(negedge clk); cyc++; k++; end while (!busy && k < 30);
        chk($sformatf("b2b%0d busy", i), busy, 1);
        h = vec[i+3].h; t = vec[i+3].t; o = vec[i+3].o;
        k = 0;
        while (!done && k < 30) begin @(negedge clk); cyc++; k++; end
        chk($sformatf("b2b%0d binary", i), binary, vec[i+2].b);
        if (i > 0) chk($sformatf("b2b%0d spacing", i), cyc - last, 12);
        last = cyc;
      end
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("b2b idle", busy, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
